// File: rtl/sram_arb.sv
// Arbitrates NREQ requesters onto one asynchronous SRAM port.
// Each access runs IDLE -> SETUP -> ACCESS (WAIT cycles) -> HOLD, and every strobe comes straight from a flop.
module sram_arb #(
  parameter int NREQ = 2,
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter int WAIT = 2,
  parameter int RR   = 0
) (
  input  logic              cpu_clk50,
  input  logic              cpu_rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     rdata,
  output logic              pause_req,
  output logic              busy,
  output logic              sram_en_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [AW-1:0]     sram_addr,
  inout  wire  [DW-1:0]     sram_data
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [2:0]      cnt_r, cnt_s;
  logic [IW-1:0]   idx_r, idx_s, last_r, last_s, win_s;
  logic [CW-1:0]   c_s;
  logic            we_r, we_s;
  logic [AW-1:0]   addr_s;
  logic [DW-1:0]   wdata_r, wdata_s, rdata_s;
  logic            drive_r, drive_s;
  logic            en_n_s, oe_n_s, we_n_s, busy_s, pause_s;
  logic [NREQ-1:0] ack_s, served_s;

  // Winner search; iterating from the far end lets the nearest candidate overwrite the rest
  always_comb begin
    win_s = '0;
    c_s   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (RR != 0) begin
        c_s = {1'b0, last_r} + CW'(k + 1);
        c_s = (c_s >= CW'(NREQ)) ? c_s - CW'(NREQ) : c_s;
      end else begin
        c_s = CW'(k);
      end
      win_s = req[c_s[IW-1:0]] ? c_s[IW-1:0] : win_s;
    end
  end

  // Next state, latched request fields and next strobe values
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    last_s  = last_r;
    we_s    = we_r;
    addr_s  = sram_addr;
    wdata_s = wdata_r;
    rdata_s = rdata;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_s = SETUP;
          idx_s   = win_s;
          last_s  = win_s;
          we_s    = we[win_s];
          addr_s  = addr[win_s*AW +: AW];
          wdata_s = wdata[win_s*DW +: DW];
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        state_s = ACCESS;
        cnt_s   = 3'd0;
      end
      ACCESS: begin
        if (cnt_r == 3'(WAIT - 1)) begin
          state_s = HOLD;
          rdata_s = we_r ? rdata : sram_data;
        end else begin
          cnt_s = cnt_r + 3'd1;
        end
      end
      HOLD:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    // Strobes are decoded from the state being entered so they line up with it once registered
    en_n_s   = (state_s == IDLE);
    oe_n_s   = ~(~we_s && ((state_s == SETUP) || (state_s == ACCESS)));
    we_n_s   = ~(we_s && (state_s == ACCESS));
    drive_s  = we_s && (state_s != IDLE);
    busy_s   = (state_s != IDLE);
    ack_s    = (state_s == HOLD) ? (NREQ'(1'b1) << idx_s) : '0;
    served_s = (state_s != IDLE) ? (NREQ'(1'b1) << idx_s) : '0;
    pause_s  = |(req & ~served_s);
  end

  // State register and registered outputs
  always_ff @(posedge cpu_clk50 or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_r   <= IDLE;
      cnt_r     <= 3'd0;
      idx_r     <= '0;
      last_r    <= IW'(NREQ - 1);
      we_r      <= 1'b0;
      wdata_r   <= '0;
      drive_r   <= 1'b0;
      rdata     <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      pause_req <= 1'b0;
      sram_en_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_addr <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      last_r    <= last_s;
      we_r      <= we_s;
      wdata_r   <= wdata_s;
      drive_r   <= drive_s;
      rdata     <= rdata_s;
      ack       <= ack_s;
      busy      <= busy_s;
      pause_req <= pause_s;
      sram_en_n <= en_n_s;
      sram_oe_n <= oe_n_s;
      sram_we_n <= we_n_s;
      sram_addr <= addr_s;
    end
  end

  assign sram_data = drive_r ? wdata_r : {DW{1'bz}};

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb: four instances (base, 4-channel round-robin, WAIT=7, WAIT=1) driven in turn.
module tb_sram_arb;

  logic cpu_clk50 = 1'b0;
  logic cpu_rst;
  always #10 cpu_clk50 = ~cpu_clk50;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instance A: NREQ=2 WAIT=2 RR=0, with an SRAM model on its bus
  logic [1:0]  req_a, we_a, ack_a;
  logic [31:0] addr_a, wdata_a;
  logic [15:0] rdata_a, saddr_a;
  logic        pause_a, busy_a, en_a, oe_a, wen_a;
  wire  [15:0] bus_a;
  logic [15:0] mem [0:255];

  assign bus_a = (!en_a && !oe_a) ? mem[saddr_a[7:0]] : 16'hzzzz;
  always @(posedge cpu_clk50) if (!en_a && !wen_a) mem[saddr_a[7:0]] <= bus_a;

  sram_arb u_a (
    .cpu_clk50(cpu_clk50), .cpu_rst(cpu_rst), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .ack(ack_a), .rdata(rdata_a), .pause_req(pause_a), .busy(busy_a),
    .sram_en_n(en_a), .sram_oe_n(oe_a), .sram_we_n(wen_a), .sram_addr(saddr_a), .sram_data(bus_a)
  );

  // Instance B: NREQ=4 RR=1 WAIT=2
  logic [3:0]  req_b, we_b, ack_b;
  logic [63:0] addr_b, wdata_b;
  logic [15:0] rdata_b, saddr_b;
  logic        pause_b, busy_b, en_b, oe_b, wen_b;
  wire  [15:0] bus_b;

  sram_arb #(.NREQ(4), .RR(1)) u_b (
    .cpu_clk50(cpu_clk50), .cpu_rst(cpu_rst), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .ack(ack_b), .rdata(rdata_b), .pause_req(pause_b), .busy(busy_b),
    .sram_en_n(en_b), .sram_oe_n(oe_b), .sram_we_n(wen_b), .sram_addr(saddr_b), .sram_data(bus_b)
  );

  // Instance C: WAIT=7
  logic [1:0]  req_c, we_c, ack_c;
  logic [31:0] addr_c, wdata_c;
  logic [15:0] rdata_c, saddr_c;
  logic        pause_c, busy_c, en_c, oe_c, wen_c;
  wire  [15:0] bus_c;

  sram_arb #(.WAIT(7)) u_c (
    .cpu_clk50(cpu_clk50), .cpu_rst(cpu_rst), .req(req_c), .we(we_c), .addr(addr_c),
    .wdata(wdata_c), .ack(ack_c), .rdata(rdata_c), .pause_req(pause_c), .busy(busy_c),
    .sram_en_n(en_c), .sram_oe_n(oe_c), .sram_we_n(wen_c), .sram_addr(saddr_c), .sram_data(bus_c)
  );

  // Instance D: WAIT=1
  logic [1:0]  req_d, we_d, ack_d;
  logic [31:0] addr_d, wdata_d;
  logic [15:0] rdata_d, saddr_d;
  logic        pause_d, busy_d, en_d, oe_d, wen_d;
  wire  [15:0] bus_d;

  sram_arb #(.WAIT(1)) u_d (
    .cpu_clk50(cpu_clk50), .cpu_rst(cpu_rst), .req(req_d), .we(we_d), .addr(addr_d),
    .wdata(wdata_d), .ack(ack_d), .rdata(rdata_d), .pause_req(pause_d), .busy(busy_d),
    .sram_en_n(en_d), .sram_oe_n(oe_d), .sram_we_n(wen_d), .sram_addr(saddr_d), .sram_data(bus_d)
  );

  task automatic next_cycle();
    @(posedge cpu_clk50);
    #1;
  endtask

  initial begin
    logic [31:0] e;
    cpu_rst = 1'b0;
    req_a = 2'b00; we_a = 2'b00; addr_a = 32'h0; wdata_a = 32'h0;
    req_b = 4'h0;  we_b = 4'h0;  addr_b = 64'h0; wdata_b = 64'h0;
    req_c = 2'b00; we_c = 2'b00; addr_c = 32'h0; wdata_c = 32'h0;
    req_d = 2'b00; we_d = 2'b00; addr_d = 32'h0; wdata_d = 32'h0;

    #25;
    check_val("rst A ctl", {25'h0, ack_a, busy_a, pause_a, en_a, oe_a, wen_a}, 32'h7);
    check_val("rst B ctl", {23'h0, ack_b, busy_b, pause_b, en_b, oe_b, wen_b}, 32'h7);
    check_val("rst C ctl", {25'h0, ack_c, busy_c, pause_c, en_c, oe_c, wen_c}, 32'h7);
    check_val("rst D ctl", {25'h0, ack_d, busy_d, pause_d, en_d, oe_d, wen_d}, 32'h7);
    check_val("rst A addr/rdata", {saddr_a, rdata_a}, 32'h0);
    check_val("rst B addr/rdata", {saddr_b, rdata_b}, 32'h0);
    check_val("rst C addr/rdata", {saddr_c, rdata_c}, 32'h0);
    check_val("rst D addr/rdata", {saddr_d, rdata_d}, 32'h0);
    #15 cpu_rst = 1'b1;
    next_cycle();

    // ch1 write 0xBEEF to 0x0010
    req_a = 2'b10; we_a = 2'b10; addr_a = {16'h0010, 16'h0000}; wdata_a = {16'hBEEF, 16'h0000};
    for (int c = 0; c < 7; c++) begin
      @(negedge cpu_clk50);
      check_val($sformatf("wr we_n c%0d", c), {31'h0, wen_a}, (c == 2 || c == 3) ? 32'h0 : 32'h1);
      check_val($sformatf("wr en_n c%0d", c), {31'h0, en_a}, (c >= 1 && c <= 4) ? 32'h0 : 32'h1);
      check_val($sformatf("wr oe_n c%0d", c), {31'h0, oe_a}, 32'h1);
      check_val($sformatf("wr ack c%0d", c), {30'h0, ack_a}, (c == 4) ? 32'h2 : 32'h0);
      if (c >= 1 && c <= 4) begin
        check_val($sformatf("wr bus c%0d", c), {16'h0, bus_a}, 32'hBEEF);
        check_val($sformatf("wr addr c%0d", c), {16'h0, saddr_a}, 32'h0010);
      end
      if (c == 4) req_a = 2'b00;
      next_cycle();
    end

    // ch0 read back 0x0010
    req_a = 2'b01; we_a = 2'b00; addr_a = {16'h0000, 16'h0010};
    for (int c = 0; c < 7; c++) begin
      @(negedge cpu_clk50);
      check_val($sformatf("rd oe_n c%0d", c), {31'h0, oe_a}, (c >= 1 && c <= 3) ? 32'h0 : 32'h1);
      check_val($sformatf("rd we_n c%0d", c), {31'h0, wen_a}, 32'h1);
      check_val($sformatf("rd ack c%0d", c), {30'h0, ack_a}, (c == 4) ? 32'h1 : 32'h0);
      check_val($sformatf("rd busy c%0d", c), {31'h0, busy_a}, (c >= 1 && c <= 4) ? 32'h1 : 32'h0);
      if (c >= 4) check_val($sformatf("rd rdata c%0d", c), {16'h0, rdata_a}, 32'hBEEF);
      if (c == 4) req_a = 2'b00;
      next_cycle();
    end

    // ch0 write withdrawn and changed right after the latch cycle
    req_a = 2'b01; we_a = 2'b01; addr_a = {16'h0000, 16'h0030}; wdata_a = {16'h0000, 16'h5555};
    for (int c = 0; c < 7; c++) begin
      @(negedge cpu_clk50);
      check_val($sformatf("wd ack c%0d", c), {30'h0, ack_a}, (c == 4) ? 32'h1 : 32'h0);
      if (c >= 1 && c <= 4) begin
        check_val($sformatf("wd addr c%0d", c), {16'h0, saddr_a}, 32'h0030);
        check_val($sformatf("wd bus c%0d", c), {16'h0, bus_a}, 32'h5555);
      end
      if (c == 6) check_val("wd rdata kept", {16'h0, rdata_a}, 32'hBEEF);
      if (c == 1) begin
        req_a = 2'b00; addr_a = {16'h0000, 16'h0077}; wdata_a = {16'h0000, 16'h1111};
      end
      next_cycle();
    end

    // Fixed priority: both requesting, ch0 always wins
    req_a = 2'b11; we_a = 2'b00; addr_a = {16'h0030, 16'h0030};
    for (int c = 0; c <= 20; c++) begin
      @(negedge cpu_clk50);
      check_val($sformatf("fp ack c%0d", c), {30'h0, ack_a}, (c % 5 == 4) ? 32'h1 : 32'h0);
      check_val($sformatf("fp busy c%0d", c), {31'h0, busy_a}, (c % 5 != 0) ? 32'h1 : 32'h0);
      if (c >= 1) check_val($sformatf("fp pause c%0d", c), {31'h0, pause_a}, 32'h1);
      if (c == 4) check_val("fp rdata", {16'h0, rdata_a}, 32'h5555);
      if (c == 20) req_a = 2'b00;
      next_cycle();
    end

    // Round-robin across four channels
    req_b = 4'hF; we_b = 4'h0; addr_b = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    for (int c = 0; c <= 24; c++) begin
      @(negedge cpu_clk50);
      e = (c % 5 == 4) ? (32'h1 << ((c / 5) % 4)) : 32'h0;
      check_val($sformatf("rr ack c%0d", c), {28'h0, ack_b}, e);
      if (c % 5 == 1) check_val($sformatf("rr addr c%0d", c), {16'h0, saddr_b}, 32'h0100 + 32'((c / 5) % 4));
      if (c == 24) req_b = 4'h0;
      next_cycle();
    end

    // WAIT=7 write, reset in the third ACCESS cycle
    req_c = 2'b01; we_c = 2'b01; addr_c = {16'h0000, 16'h0020}; wdata_c = {16'h0000, 16'h1234};
    for (int c = 0; c < 4; c++) begin
      @(negedge cpu_clk50);
      check_val($sformatf("w7 we_n c%0d", c), {31'h0, wen_c}, (c >= 2) ? 32'h0 : 32'h1);
      if (c >= 1) check_val($sformatf("w7 bus c%0d", c), {16'h0, bus_c}, 32'h1234);
      next_cycle();
    end
    @(negedge cpu_clk50);
    check_val("w7 we_n c4", {31'h0, wen_c}, 32'h0);
    #2 cpu_rst = 1'b0;
    req_c = 2'b00;
    #1;
    check_val("w7 rst ctl", {25'h0, ack_c, busy_c, pause_c, en_c, oe_c, wen_c}, 32'h7);
    check_val("w7 rst addr", {16'h0, saddr_c}, 32'h0);
    @(negedge cpu_clk50);
    cpu_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge cpu_clk50);
      check_val($sformatf("w7 idle k%0d", k), {28'h0, ack_c, busy_c, en_c}, 32'h1);
    end
    next_cycle();
    req_c = 2'b01; we_c = 2'b01; addr_c = {16'h0000, 16'h0021}; wdata_c = {16'h0000, 16'hCAFE};
    for (int c = 0; c < 12; c++) begin
      @(negedge cpu_clk50);
      check_val($sformatf("w7b ack c%0d", c), {30'h0, ack_c}, (c == 9) ? 32'h1 : 32'h0);
      check_val($sformatf("w7b we_n c%0d", c), {31'h0, wen_c}, (c >= 2 && c <= 8) ? 32'h0 : 32'h1);
      if (c >= 1 && c <= 9) check_val($sformatf("w7b bus c%0d", c), {16'h0, bus_c}, 32'hCAFE);
      if (c == 9) req_c = 2'b00;
      next_cycle();
    end

    // WAIT=1, ch0 held across ack gives back-to-back transactions
    req_d = 2'b01; we_d = 2'b00; addr_d = {16'h0000, 16'h0040};
    for (int c = 0; c < 10; c++) begin
      @(negedge cpu_clk50);
      check_val($sformatf("w1 ack c%0d", c), {30'h0, ack_d}, (c == 3 || c == 7) ? 32'h1 : 32'h0);
      check_val($sformatf("w1 oe_n c%0d", c), {31'h0, oe_d},
                (c == 1 || c == 2 || c == 5 || c == 6) ? 32'h0 : 32'h1);
      check_val($sformatf("w1 busy c%0d", c), {31'h0, busy_d},
                ((c >= 1 && c <= 3) || (c >= 5 && c <= 7)) ? 32'h1 : 32'h0);
      if (c == 7) req_d = 2'b00;
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
